// File: rtl/note_sprite_arbiter.sv
// Round-robin arbiter sharing one 40x40 sprite ROM among note lanes, with a fixed 3-cycle response pipe.
// Optional macro SPRITE_TRANSPARENCY_EN: treat KEY_COLOR pixels as not opaque.
module note_sprite_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned SPRITE_W  = 40,
    parameter int unsigned SPRITE_H  = 40,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [6*N_REQ-1:0]   req_x,
    input  logic [6*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]     gnt,
    output logic [12:0]          rom_addr,
    input  logic [23:0]          rom_data,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_id,
    output logic [23:0]          rsp_data,
    output logic                 rsp_opaque,
    output logic                 rsp_err
);
    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned OFF_W  = 6;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              hit;
    logic [PTR_W-1:0]  sel;
    logic [OFF_W-1:0]  sel_x;
    logic [OFF_W-1:0]  sel_y;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    int unsigned       idx;

    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic              s1_err;
    logic              s2_valid;
    logic [ID_W-1:0]   s2_id;
    logic              s2_err;
    logic              key_hit;

    // Search lanes starting at ptr; the first requester wins.
    always_comb begin
        hit   = 1'b0;
        sel   = '0;
        sel_x = '0;
        sel_y = '0;
        idx   = 0;
        gnt   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!hit && (j == idx) && req[j]) begin
                    hit   = 1'b1;
                    sel   = PTR_W'(j);
                    sel_x = req_x[OFF_W*j +: OFF_W];
                    sel_y = req_y[OFF_W*j +: OFF_W];
                end
            end
        end
        if (Reset) begin
            hit = 1'b0;
        end
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (hit && (PTR_W'(j) == sel)) begin
                gnt[j] = 1'b1;
            end
        end
    end

    // Address and range check for the granted lane.
    always_comb begin
        sel_err  = (32'(sel_x) >= SPRITE_W) || (32'(sel_y) >= SPRITE_H);
        sel_addr = ADDR_W'(sel_y) * ADDR_W'(SPRITE_W) + ADDR_W'(sel_x);
        ptr_nxt  = ((32'(sel) + 1) >= N_REQ) ? '0 : PTR_W'(32'(sel) + 1);
    end

`ifdef SPRITE_TRANSPARENCY_EN
    assign key_hit = (rom_data == KEY_COLOR);
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOR;
    assign key_hit    = 1'b0;
`endif

    // S1 address/tag, S2 tag alongside ROM read, S3 response.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr        <= '0;
            rom_addr   <= '0;
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_err     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_id      <= '0;
            s2_err     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_opaque <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (hit) begin
                ptr <= ptr_nxt;
            end
            s1_valid   <= hit;
            s1_id      <= hit ? ID_W'(sel) : '0;
            s1_err     <= hit && sel_err;
            rom_addr   <= (hit && !sel_err) ? sel_addr : '0;
            s2_valid   <= s1_valid;
            s2_id      <= s1_id;
            s2_err     <= s1_err;
            rsp_valid  <= s2_valid;
            rsp_id     <= s2_valid ? s2_id : '0;
            rsp_err    <= s2_valid && s2_err;
            rsp_data   <= (s2_valid && !s2_err) ? rom_data : '0;
            rsp_opaque <= s2_valid && !s2_err && !key_hit;
        end
    end
endmodule

// File: tb/tb_note_sprite_arbiter.sv
// Self-checking bench for note_sprite_arbiter: directed table, hand sequences, random traffic vs queue model.
module tb_note_sprite_arbiter;
    localparam int N = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [3:0]    req;
    logic [23:0]   req_x;
    logic [23:0]   req_y;
    logic [3:0]    gnt;
    logic [12:0]   rom_addr;
    logic [23:0]   rom_data;
    logic          rsp_valid;
    logic [2:0]    rsp_id;
    logic [23:0]   rsp_data;
    logic          rsp_opaque;
    logic          rsp_err;

    note_sprite_arbiter #(.N_REQ(4), .SPRITE_W(40), .SPRITE_H(40), .KEY_COLOR(24'hFF00FF)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_x(req_x), .req_y(req_y), .gnt(gnt),
        .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_opaque(rsp_opaque), .rsp_err(rsp_err)
    );

    always #5 Clk = ~Clk;

    logic [23:0] mem [0:1599];
    always @(posedge Clk) begin
        if (rom_addr < 13'd1600) rom_data <= mem[rom_addr];
        else rom_data <= 24'hDEAD00;
    end

    typedef struct { int due; int id; int addr; bit err; } exp_t;
    exp_t q[$];
    int   rsp_log[$];
    int   tests = 0;
    int   fails = 0;
    int   mptr  = 0;
    int   cyc   = 0;
    logic [3:0]  last_gnt;
    logic [12:0] last_addr;
    logic [23:0] last_data;
    logic        last_op;
    logic        last_err;
    int          last_id;

    function automatic void chk(string name, longint got, longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic bit exp_opaque(int addr, bit err);
`ifdef SPRITE_TRANSPARENCY_EN
        return !err && (mem[addr] != 24'hFF00FF);
`else
        return !err;
`endif
    endfunction

    // One clock: check gnt before the edge, rom_addr and responses after it.
    task automatic step();
        int k, x, y, addr;
        bit err;
        logic [3:0] eg;
        exp_t e;
        #1;
        k = -1; eg = 4'b0; addr = 0; err = 0;
        if (!Reset) begin
            for (int i = 0; i < N; i++) begin
                int l;
                l = (mptr + i) % N;
                if (k < 0 && ((req >> l) & 4'b1) != 4'b0) k = l;
            end
        end
        if (k >= 0) eg = 4'b1 << k;
        last_gnt = gnt;
        chk("gnt", gnt, eg);
        if (k >= 0) begin
            x = int'((req_x >> (6*k)) & 24'h3f);
            y = int'((req_y >> (6*k)) & 24'h3f);
            err = (x >= 40) || (y >= 40);
            addr = err ? 0 : y*40 + x;
            e.due = cyc + 2; e.id = k; e.addr = addr; e.err = err;
            q.push_back(e);
            mptr = (k + 1) % N;
        end
        @(posedge Clk);
        if (Reset) begin
            q.delete();
            mptr = 0;
            k = -1;
        end
        @(negedge Clk);
        last_addr = rom_addr;
        if (k >= 0) chk("rom_addr", rom_addr, addr);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_data", rsp_data, e.err ? 0 : mem[e.addr]);
            chk("rsp_opaque", rsp_opaque, exp_opaque(e.addr, e.err));
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
        end
        if (rsp_valid) begin
            rsp_log.push_back(int'(rsp_id));
            last_id = int'(rsp_id); last_data = rsp_data; last_op = rsp_opaque; last_err = rsp_err;
        end
        cyc++;
    endtask

    task automatic idle(int n);
        req = 4'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct { logic [3:0] r; int x; int y; logic [3:0] egnt; int eaddr; bit eerr; bit eop_key; } vec_t;
    vec_t tbl[10];

    logic [3:0] gseq [0:7];
    logic [3:0] gexp [0:7];

    initial begin
        for (int i = 0; i < 1600; i++) begin
            mem[i] = 24'($urandom);
            if (mem[i] == 24'hFF00FF) mem[i] = 24'h0;
        end
        mem[0] = 24'hFF00FF;
        mem[1] = 24'h00FF00;

        tbl[0] = '{4'b0001,  5,  2, 4'b0001,   85, 0, 1};
        tbl[1] = '{4'b0100, 39, 39, 4'b0100, 1599, 0, 1};
        tbl[2] = '{4'b0010, 40,  0, 4'b0010,    0, 1, 0};
        tbl[3] = '{4'b1111,  1,  0, 4'b0100,    1, 0, 1};
        tbl[4] = '{4'b0011,  0,  1, 4'b0001,   40, 0, 1};
        tbl[5] = '{4'b0000,  0,  0, 4'b0000,    0, 0, 0};
        tbl[6] = '{4'b1001, 63, 63, 4'b1000,    0, 1, 0};
        tbl[7] = '{4'b0010,  0, 40, 4'b0010,    0, 1, 0};
        tbl[8] = '{4'b0001,  0,  0, 4'b0001,    0, 0, 0};
        tbl[9] = '{4'b0001,  1,  0, 4'b0001,    1, 0, 1};

        Reset = 1'b1; req = 4'b0; req_x = '0; req_y = '0;
        step(); step();
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_data, rsp_opaque, rsp_err}, 0);
        Reset = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            req   = tbl[i].r;
            req_x = {4{6'(tbl[i].x)}};
            req_y = {4{6'(tbl[i].y)}};
            step();
            chk("tbl_gnt", last_gnt, tbl[i].egnt);
            if (tbl[i].egnt != 4'b0) begin
                chk("tbl_addr", last_addr, tbl[i].eaddr);
                idle(3);
                chk("tbl_err", last_err, tbl[i].eerr);
`ifdef SPRITE_TRANSPARENCY_EN
                chk("tbl_opaque", last_op, tbl[i].eop_key);
`else
                chk("tbl_opaque", last_op, !tbl[i].eerr);
`endif
            end else begin
                idle(3);
            end
        end

        // Full contention from reset
        Reset = 1'b1; idle(1); Reset = 1'b0;
        rsp_log.delete();
        req = 4'b1111; req_x = '0; req_y = {4{6'd3}};
        for (int i = 0; i < 8; i++) begin
            gexp[i] = 4'b1 << (i % 4);
            step();
            gseq[i] = last_gnt;
        end
        idle(4);
        for (int i = 0; i < 8; i++) chk("rr_gnt", gseq[i], gexp[i]);
        chk("rr_count", rsp_log.size(), 8);
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) chk("rr_id", rsp_log[i], i % 4);

        // Reset squashes in-flight reads
        rsp_log.delete();
        req = 4'b0001; step();
        req = 4'b0010; step();
        Reset = 1'b1; req = 4'b1111; step();
        Reset = 1'b0;
        idle(6);
        chk("squash_count", rsp_log.size(), 0);
        req = 4'b1000; step();
        chk("post_reset_l3", last_gnt, 4'b1000);
        idle(3);
        req = 4'b1111; step();
        chk("post_reset_rr", last_gnt, 4'b0001);
        idle(4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            Reset = ($urandom_range(0, 39) == 0);
            req   = 4'($urandom);
            for (int l = 0; l < N; l++) begin
                req_x[6*l +: 6] = 6'($urandom_range(0, 45));
                req_y[6*l +: 6] = 6'($urandom_range(0, 45));
            end
            step();
        end
        Reset = 1'b0;
        idle(4);
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
